// File: rtl/if_stage.sv
// Instruction fetch stage: drives the instruction SRAM and feeds the IF/ID
// registers, with stall hold, memory-port arbitration and branch squash.
module if_stage #(
  parameter logic [15:0] NOP_WORD = 16'h0800,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        memBusy,
  input  logic        branchTaken,
  input  logic [15:0] branchTarget,
  output logic        instrReq,
  output logic [15:0] instrAddr,
  input  logic        instrReady,
  input  logic [15:0] instrData,
  output logic [15:0] instr,
  output logic [15:0] pcOut,
  output logic [15:0] pcPlus1
);

  typedef enum logic [1:0] {BOOT, FETCH, WAIT, HOLD} state_t;

  state_t      state_q;
  logic [15:0] pc_q, instr_q, pcout_q, pcplus1_q;
  logic [15:0] hold_word_q, hold_pc_q;
  logic        squash_q;
  logic [15:0] pc_inc, hold_inc;

  assign pc_inc   = pc_q + 16'd1;
  assign hold_inc = hold_pc_q + 16'd1;

  // A squashed request keeps presenting its original address until the
  // stale word arrives; hold_pc_q carries that address while in WAIT.
  assign instrAddr = squash_q ? hold_pc_q : pc_q;
  assign instr     = instr_q;
  assign pcOut     = pcout_q;
  assign pcPlus1   = pcplus1_q;

  always_comb begin
    instrReq = 1'b0;
    case (state_q)
      FETCH:   instrReq = !memBusy && !stall;
      WAIT:    instrReq = 1'b1;
      default: instrReq = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      instr_q     <= NOP_WORD;
      pcout_q     <= RESET_PC;
      pcplus1_q   <= RESET_PC + 16'd1;
      hold_word_q <= 16'h0000;
      hold_pc_q   <= 16'h0000;
      squash_q    <= 1'b0;
    end else begin
      case (state_q)
        BOOT: state_q <= FETCH;

        FETCH: begin
          if (branchTaken) begin
            pc_q    <= branchTarget;
            instr_q <= NOP_WORD;
          end else if (stall) begin
            state_q <= FETCH;
          end else if (memBusy) begin
            instr_q <= NOP_WORD;
          end else if (instrReady) begin
            instr_q   <= instrData;
            pcout_q   <= pc_q;
            pcplus1_q <= pc_inc;
            pc_q      <= pc_inc;
          end else begin
            instr_q <= NOP_WORD;
            state_q <= WAIT;
          end
        end

        WAIT: begin
          if (branchTaken) begin
            pc_q    <= branchTarget;
            instr_q <= NOP_WORD;
            if (instrReady) begin
              squash_q <= 1'b0;
              state_q  <= FETCH;
            end else begin
              squash_q <= 1'b1;
              if (!squash_q) hold_pc_q <= pc_q;
            end
          end else if (instrReady) begin
            squash_q <= 1'b0;
            state_q  <= FETCH;
            if (squash_q) begin
              if (!stall) instr_q <= NOP_WORD;
            end else if (stall) begin
              hold_word_q <= instrData;
              hold_pc_q   <= pc_q;
              state_q     <= HOLD;
            end else begin
              instr_q   <= instrData;
              pcout_q   <= pc_q;
              pcplus1_q <= pc_inc;
              pc_q      <= pc_inc;
            end
          end else if (!stall) begin
            instr_q <= NOP_WORD;
          end
        end

        HOLD: begin
          if (branchTaken) begin
            pc_q    <= branchTarget;
            instr_q <= NOP_WORD;
            state_q <= FETCH;
          end else if (!stall) begin
            instr_q   <= hold_word_q;
            pcout_q   <= hold_pc_q;
            pcplus1_q <= hold_inc;
            pc_q      <= hold_inc;
            state_q   <= FETCH;
          end
        end

        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: boot, wait states, hold buffer, squash, wrap,
// memory-port contention, branch-over-stall and reset during an outstanding fetch.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, stall, memBusy, branchTaken, instrReady;
  logic [15:0] branchTarget, instrData;
  logic        instrReq;
  logic [15:0] instrAddr, instr, pcOut, pcPlus1;
  int tests = 0;
  int fails = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .memBusy(memBusy),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .instrReq(instrReq), .instrAddr(instrAddr),
    .instrReady(instrReady), .instrData(instrData),
    .instr(instr), .pcOut(pcOut), .pcPlus1(pcPlus1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 0; memBusy = 0; branchTaken = 0; instrReady = 0;
    branchTarget = 16'h0; instrData = 16'h0;
    tick(); tick();
    tests++; if (instr !== 16'h0800) begin fails++; $display("FAIL reset_instr got %h exp %h", instr, 16'h0800); end
    tests++; if (pcOut !== 16'h0000) begin fails++; $display("FAIL reset_pcOut got %h exp %h", pcOut, 16'h0000); end
    tests++; if (pcPlus1 !== 16'h0001) begin fails++; $display("FAIL reset_pcPlus1 got %h exp %h", pcPlus1, 16'h0001); end
    tests++; if (instrReq !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", instrReq); end
    tests++; if (instrAddr !== 16'h0000) begin fails++; $display("FAIL reset_addr got %h exp %h", instrAddr, 16'h0000); end
  endtask

  task automatic test_boot_stream();
    instrReady = 1; instrData = 16'h4801;
    rst = 1'b1;
    #1;
    tests++; if (instrReq !== 1'b0) begin fails++; $display("FAIL boot_req got %b exp 0", instrReq); end
    tick();
    // BOOT ignores instrReady: nothing delivered yet
    tests++; if (instr !== 16'h0800) begin fails++; $display("FAIL boot_instr got %h exp %h", instr, 16'h0800); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (instrReq !== 1'b1 || instrAddr !== 16'(i)) begin
        fails++; $display("FAIL stream_req%0d got req=%b addr=%h exp req=1 addr=%h", i, instrReq, instrAddr, 16'(i)); end
      tick();
      tests++; if (pcOut !== 16'(i) || instr !== 16'h4801 || pcPlus1 !== 16'(i + 1)) begin
        fails++; $display("FAIL stream%0d got pc=%h instr=%h p1=%h exp pc=%h instr=4801 p1=%h", i, pcOut, instr, pcPlus1, 16'(i), 16'(i + 1)); end
    end
  endtask

  task automatic test_wait();
    instrReady = 0;
    branchTaken = 1; branchTarget = 16'h0010;
    tick();
    branchTaken = 0;
    tests++; if (instrAddr !== 16'h0010 || instrReq !== 1'b1) begin
      fails++; $display("FAIL wait_start got addr=%h req=%b exp addr=0010 req=1", instrAddr, instrReq); end
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (instr !== 16'h0800 || instrAddr !== 16'h0010 || instrReq !== 1'b1) begin
        fails++; $display("FAIL wait%0d got instr=%h addr=%h req=%b exp instr=0800 addr=0010 req=1", i, instr, instrAddr, instrReq); end
    end
    memBusy = 1; #1;
    tests++; if (instrReq !== 1'b1) begin fails++; $display("FAIL wait_membusy_req got %b exp 1", instrReq); end
    memBusy = 0;
    instrReady = 1; instrData = 16'hA5A5;
    tick();
    tests++; if (instr !== 16'hA5A5 || pcOut !== 16'h0010 || pcPlus1 !== 16'h0011 || instrAddr !== 16'h0011) begin
      fails++; $display("FAIL wait_deliver got instr=%h pc=%h p1=%h addr=%h exp A5A5 0010 0011 0011", instr, pcOut, pcPlus1, instrAddr); end
  endtask

  task automatic test_hold();
    instrReady = 0;
    tick();
    tests++; if (instr !== 16'h0800) begin fails++; $display("FAIL hold_enter_wait got %h exp 0800", instr); end
    stall = 1; instrReady = 1; instrData = 16'h1234;
    tick();
    instrReady = 0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (instr !== 16'h0800 || pcOut !== 16'h0010 || pcPlus1 !== 16'h0011 || instrReq !== 1'b0) begin
        fails++; $display("FAIL hold_frozen%0d got instr=%h pc=%h p1=%h req=%b exp 0800 0010 0011 0", i, instr, pcOut, pcPlus1, instrReq); end
      if (i < 2) tick();
    end
    stall = 0; #1;
    tests++; if (instrReq !== 1'b0) begin fails++; $display("FAIL hold_release_req got %b exp 0", instrReq); end
    tick();
    tests++; if (instr !== 16'h1234 || pcOut !== 16'h0011 || pcPlus1 !== 16'h0012) begin
      fails++; $display("FAIL hold_deliver got instr=%h pc=%h p1=%h exp 1234 0011 0012", instr, pcOut, pcPlus1); end
    tick();
    tests++; if (instr !== 16'h0800 || instrAddr !== 16'h0012) begin
      fails++; $display("FAIL hold_once got instr=%h addr=%h exp 0800 0012", instr, instrAddr); end
  endtask

  task automatic test_squash();
    // already in WAIT for 0x0012
    branchTaken = 1; branchTarget = 16'h0123;
    tick();
    branchTaken = 0;
    tests++; if (instr !== 16'h0800 || instrAddr !== 16'h0012 || instrReq !== 1'b1) begin
      fails++; $display("FAIL squash_wait got instr=%h addr=%h req=%b exp 0800 0012 1", instr, instrAddr, instrReq); end
    instrReady = 1; instrData = 16'hBEEF;
    tick();
    tests++; if (instr !== 16'h0800 || pcOut !== 16'h0011) begin
      fails++; $display("FAIL squash_drop got instr=%h pc=%h exp 0800 0011", instr, pcOut); end
    tests++; if (instrAddr !== 16'h0123 || instrReq !== 1'b1) begin
      fails++; $display("FAIL squash_redirect got addr=%h req=%b exp 0123 1", instrAddr, instrReq); end
    instrData = 16'h5555;
    tick();
    tests++; if (instr !== 16'h5555 || pcOut !== 16'h0123) begin
      fails++; $display("FAIL squash_next got instr=%h pc=%h exp 5555 0123", instr, pcOut); end
  endtask

  task automatic test_wrap();
    branchTaken = 1; branchTarget = 16'hFFFF;
    tick();
    branchTaken = 0; instrData = 16'h7777;
    tick();
    tests++; if (pcOut !== 16'hFFFF || pcPlus1 !== 16'h0000 || instr !== 16'h7777 || instrAddr !== 16'h0000) begin
      fails++; $display("FAIL wrap got pc=%h p1=%h instr=%h addr=%h exp FFFF 0000 7777 0000", pcOut, pcPlus1, instr, instrAddr); end
  endtask

  task automatic test_membusy();
    memBusy = 1; instrData = 16'h3333;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (instrReq !== 1'b0) begin fails++; $display("FAIL membusy_req%0d got %b exp 0", i, instrReq); end
      tick();
      tests++; if (instr !== 16'h0800 || instrAddr !== 16'h0000 || pcOut !== 16'hFFFF) begin
        fails++; $display("FAIL membusy%0d got instr=%h addr=%h pc=%h exp 0800 0000 FFFF", i, instr, instrAddr, pcOut); end
    end
    memBusy = 0;
  endtask

  task automatic test_branch_over_stall();
    instrReady = 1; instrData = 16'h4444;
    tick();
    stall = 1; branchTaken = 1; branchTarget = 16'h0200;
    tick();
    branchTaken = 0;
    tests++; if (instr !== 16'h0800 || instrAddr !== 16'h0200 || pcOut !== 16'h0000) begin
      fails++; $display("FAIL br_stall got instr=%h addr=%h pc=%h exp 0800 0200 0000", instr, instrAddr, pcOut); end
    tick();
    tests++; if (instr !== 16'h0800 || instrAddr !== 16'h0200) begin
      fails++; $display("FAIL stall_hold got instr=%h addr=%h exp 0800 0200", instr, instrAddr); end
    stall = 0;
  endtask

  task automatic test_reset_mid_wait();
    instrReady = 0;
    tick();
    tests++; if (instrReq !== 1'b1) begin fails++; $display("FAIL rmw_wait got req=%b exp 1", instrReq); end
    rst = 0; #1;
    tests++; if (instrReq !== 1'b0 || instrAddr !== 16'h0000 || instr !== 16'h0800) begin
      fails++; $display("FAIL rmw_async got req=%b addr=%h instr=%h exp 0 0000 0800", instrReq, instrAddr, instr); end
    tick();
    instrReady = 1; instrData = 16'h9999;
    rst = 1;
    tick();
    tests++; if (instr !== 16'h0800 || pcOut !== 16'h0000) begin
      fails++; $display("FAIL rmw_boot_ignore got instr=%h pc=%h exp 0800 0000", instr, pcOut); end
    tick();
    tests++; if (instr !== 16'h9999 || pcOut !== 16'h0000 || instrAddr !== 16'h0001) begin
      fails++; $display("FAIL rmw_first got instr=%h pc=%h addr=%h exp 9999 0000 0001", instr, pcOut, instrAddr); end
  endtask

  initial begin
    test_reset();
    test_boot_stream();
    test_wait();
    test_hold();
    test_squash();
    test_wrap();
    test_membusy();
    test_branch_over_stall();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
